// File: rtl/letter_display_scanner.sv
// letter_display_scanner: multiplexed 7-segment driver for a shift-in letter buffer.
// Letters arrive through a valid/ready port and shift into digit 0, pushing older
// letters left. A phase counter divides each digit slot into a blanked guard
// interval followed by the lit interval, so anodes never overlap between digits.
// Optional feature: define LETTER_DISPLAY_BLINK_EN to blink digit 0 for 64 full
// scans after every accepted letter.
module letter_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [4:0]                    wr_letter,
    output logic                          wr_ready,
    input  logic                          clear,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PH_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(SCAN_DIV - 1);
    localparam logic [PH_W-1:0]       PH_GUARD = PH_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0]            BLANK    = 5'd31;

    // Inactive output levels; XOR with these converts active-high drive to pin polarity.
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

    typedef enum logic {
        ST_GUARD,
        ST_ON
    } state_t;

    // Active-high segment pattern for a letter code (a..g = bits 6..0).
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'h77;
            5'd1:    g = 7'h1F;
            5'd2:    g = 7'h4E;
            5'd3:    g = 7'h3D;
            5'd4:    g = 7'h4F;
            5'd5:    g = 7'h47;
            5'd6:    g = 7'h7B;
            5'd7:    g = 7'h37;
            5'd8:    g = 7'h30;
            5'd9:    g = 7'h38;
            5'd10:   g = 7'h07;
            5'd11:   g = 7'h0E;
            5'd12:   g = 7'h54;
            5'd13:   g = 7'h76;
            5'd14:   g = 7'h7E;
            5'd15:   g = 7'h67;
            5'd16:   g = 7'h73;
            5'd17:   g = 7'h46;
            5'd18:   g = 7'h5B;
            5'd19:   g = 7'h0F;
            5'd20:   g = 7'h3E;
            5'd21:   g = 7'h1C;
            5'd22:   g = 7'h2A;
            5'd23:   g = 7'h31;
            5'd24:   g = 7'h3B;
            5'd25:   g = 7'h6D;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [1:0]            sync_q;
    logic                  run;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    state_t                state_q, state_d;
    logic [4:0]            buf_q [NUM_DIGITS];
    logic [4:0]            buf_d [NUM_DIGITS];
    logic                  accept;
    logic                  scan_end;
    logic [6:0]            seg_raw, seg_q;
    logic [NUM_DIGITS-1:0] an_raw, an_q;
`ifdef LETTER_DISPLAY_BLINK_EN
    logic [6:0]            blink_q, blink_d;
`endif

    // Clear always wins over a simultaneous write, so ready simply mirrors !clear.
    assign wr_ready  = !clear;
    assign accept    = wr_valid && wr_ready;
    assign run       = sync_q[1];
    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

    // Two-flop release synchroniser; scanning starts once the release reaches stage 1.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: every clocked block uses non-blocking assignments so all flops
        // sample pre-edge values; blocking here would create order-dependent races.
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end

    // Next-state logic: phase/digit counters, scan FSM, buffer update and output decode.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave a value unassigned and infer a latch.
        phase_d  = phase_q;
        idx_d    = idx_q;
        state_d  = state_q;
        scan_end = 1'b0;
        buf_d    = buf_q;
        seg_raw  = 7'h00;
        an_raw   = '0;

        if (run) begin
            if (phase_q == PH_LAST) begin
                phase_d  = '0;
                scan_end = (idx_q == IDX_LAST);
                idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        case (state_q)
            ST_GUARD: if (phase_d == PH_GUARD) state_d = ST_ON;
            ST_ON:    if (phase_d == '0)       state_d = ST_GUARD;
            default:                           state_d = ST_GUARD;
        endcase

        if (clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) buf_d[k] = BLANK;
        end else if (accept) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--) buf_d[k] = buf_q[k-1];
            buf_d[0] = wr_letter;
        end

`ifdef LETTER_DISPLAY_BLINK_EN
        blink_d = blink_q;
        if (accept)                          blink_d = 7'd64;
        else if (scan_end && blink_q != '0)  blink_d = blink_q - 1'b1;
`endif

        // Anode depends only on the counters, so writes can never glitch it.
        if (state_d == ST_ON) begin
            an_raw[idx_d] = 1'b1;
            seg_raw       = glyph(buf_d[idx_d]);
`ifdef LETTER_DISPLAY_BLINK_EN
            // Odd remaining counts are the blanked scans of the blink window.
            if (idx_d == '0 && blink_d[0]) seg_raw = 7'h00;
`endif
        end
    end

    // Scan counters, FSM state and pin-polarity output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            idx_q   <= '0;
            state_q <= ST_GUARD;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_raw ^ SEG_OFF;
            an_q    <= an_raw ^ AN_OFF;
        end
    end

    // Letter buffer; reset forces every entry blank so a pending write is dropped whole.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: this small register-based buffer is reset deliberately: the display
        // must come up blank. Large RAM-style arrays are normally left unreset.
        if (!reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) buf_q[k] <= BLANK;
        end else begin
            buf_q <= buf_d;
        end
    end

`ifdef LETTER_DISPLAY_BLINK_EN
    // Remaining blink scans after the most recent accepted letter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blink_q <= '0;
        else          blink_q <= blink_d;
    end
`endif

endmodule
